// File: rtl/bsg_wormhole_router_adapter_in_multi.sv
`default_nettype none
// ============================================================================
// Module   : bsg_wormhole_router_adapter_in_multi
// Purpose  : Round-robin arbitrates among num_in_p packet sources and
//            serializes the granted packet {payload, len, cord} into
//            flit_width_p flits on one ready-and wormhole link. Packets whose
//            len needs more flits than the packet can hold are consumed and
//            reported on drop_o / drop_id_o instead of being sent.
// Ports    : clk_i, reset_n_i (async, active-low)
//            packet_i / v_i / ready_o : per-source packet handshake
//            link_o  : {v, ready_and_rev(=0), data} to the router
//            link_i  : {v, ready_and_rev, data}; only ready_and_rev is used
//            drop_o  : one-cycle drop pulse; drop_id_o : source of last drop
// Revision : 1.0  initial release
// ============================================================================
module bsg_wormhole_router_adapter_in_multi #(
  parameter int num_in_p            = 2,
  parameter int max_payload_width_p = 64,
  parameter int len_width_p         = 4,
  parameter int cord_width_p        = 5,
  parameter int flit_width_p        = 16,
  localparam int pw        = max_payload_width_p + len_width_p + cord_width_p,
  localparam int max_flits = (pw + flit_width_p - 1) / flit_width_p,
  localparam int lw        = flit_width_p + 2,
  localparam int id_w      = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [num_in_p*pw-1:0]   packet_i,
  input  logic [num_in_p-1:0]      v_i,
  output logic [num_in_p-1:0]      ready_o,
  output logic [lw-1:0]            link_o,
  input  logic [lw-1:0]            link_i,
  output logic                     drop_o,
  output logic [id_w-1:0]          drop_id_o
);

  localparam int pad_w = max_flits * flit_width_p;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                  state_r, state_n;
  logic [pad_w-1:0]        pkt_r;
  logic [len_width_p-1:0]  len_r;
  logic [len_width_p-1:0]  cnt_r;
  logic [id_w-1:0]         rr_r;
  logic                    drop_r;
  logic [id_w-1:0]         drop_id_r;

  logic [pw-1:0]           pkts [num_in_p];
  logic [num_in_p-1:0]     grant;
  logic [id_w-1:0]         winner;
  logic                    found;
  logic [pw-1:0]           win_pkt;
  logic [len_width_p-1:0]  win_len;
  logic [pad_w-1:0]        win_padded;
  logic                    too_long;
  logic                    link_ready;
  logic                    last;
  logic                    acc;
  logic                    accept;
  logic                    unused_link;

  for (genvar g = 0; g < num_in_p; g++) begin : g_unpack
    assign pkts[g] = packet_i[g*pw +: pw];
  end

  assign link_ready  = link_i[flit_width_p];
  assign unused_link = ^{link_i[lw-1], link_i[flit_width_p-1:0]};

  assign last   = (cnt_r == len_r);
  // Acceptance overlaps the last-flit handshake so packets go back to back.
  assign acc    = (state_r == IDLE) || (last && link_ready);
  assign accept = acc && (|v_i);

  // Round-robin: first valid source at or above rr, then wrap below rr.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < num_in_p; i++) begin
      if (!found && v_i[i] && (i >= int'(rr_r))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        winner   = id_w'(i);
      end
    end
    for (int i = 0; i < num_in_p; i++) begin
      if (!found && v_i[i] && (i < int'(rr_r))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        winner   = id_w'(i);
      end
    end
  end

  assign win_pkt  = pkts[winner];
  assign win_len  = win_pkt[cord_width_p +: len_width_p];
  assign too_long = (32'(win_len) > 32'(max_flits - 1));

  always_comb begin
    win_padded         = '0;
    win_padded[pw-1:0] = win_pkt;
  end

  // Reset gates ready so no source sees a handshake while held in reset.
  assign ready_o = grant & {num_in_p{acc & reset_n_i}};

  always_comb begin
    state_n = state_r;
    if (acc) begin
      state_n = (accept && !too_long) ? SEND : IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // The packet register shifts down one flit per handshake, so the flit on
  // the link is always the low slice and holds while the link stalls.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_r     <= '0;
      len_r     <= '0;
      cnt_r     <= '0;
      rr_r      <= '0;
      drop_r    <= 1'b0;
      drop_id_r <= '0;
    end else begin
      drop_r <= 1'b0;
      if (accept) begin
        rr_r <= (winner == id_w'(num_in_p - 1)) ? '0 : winner + 1'b1;
        if (too_long) begin
          drop_r    <= 1'b1;
          drop_id_r <= winner;
        end else begin
          pkt_r <= win_padded;
          len_r <= win_len;
          cnt_r <= '0;
        end
      end else if ((state_r == SEND) && link_ready && !last) begin
        cnt_r <= cnt_r + 1'b1;
        pkt_r <= pkt_r >> flit_width_p;
      end
    end
  end

  assign link_o    = {(state_r == SEND), 1'b0, pkt_r[flit_width_p-1:0]};
  assign drop_o    = drop_r;
  assign drop_id_o = drop_id_r;

endmodule
`default_nettype wire
